dmem_mmio: RTL and testbench

- Parametrised data-memory successor for the single-cycle MIPS system.
- Adds the following over a plain single-cycle RAM:
  - req/ready handshake with configurable wait states;
  - byte-enable writes;
  - a small memory-mapped I/O window containing a GPIO output register and a free-running cycle counter.
- Sits between the processor (or a future multicycle core) data port and on-chip storage.

---
 rtl/dmem_mmio.sv | 141 ++++++++++++++
 tb/tb_dmem_mmio.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_mmio.sv
// Data memory with req/ready handshake, wait states, byte-enable writes and a
// 16-byte I/O window holding a GPIO register, a cycle counter and a status word.
module dmem_mmio #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DEPTH_LOG2  = 6,
    parameter int                    WAIT_STATES = 1,
    parameter logic [ADDR_WIDTH-1:0] IO_BASE     = 32'hFFFF_0000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req,
    input  logic                    we,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] be,
    output logic                    busy,
    output logic                    ready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    err,
    output logic [DATA_WIDTH-1:0]   gpio_out
);

    localparam int         NB      = DATA_WIDTH / 8;
    localparam logic [3:0] WS4     = 4'(WAIT_STATES);
    localparam logic [3:0] WS_LAST = 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t                  state, state_nxt;
    logic [3:0]              wcnt;
    logic                    we_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [NB-1:0]           be_q;
    logic [DATA_WIDTH-1:0]   cyc_cnt;
    logic [DATA_WIDTH-1:0]   mem [0:(1<<DEPTH_LOG2)-1];

    logic                    acc_we;
    logic [ADDR_WIDTH-1:0]   acc_addr;
    logic [DATA_WIDTH-1:0]   acc_wdata;
    logic [NB-1:0]           acc_be;
    logic [ADDR_WIDTH-1:0]   offset;
    logic                    in_io;
    logic [1:0]              io_sel;
    logic [DEPTH_LOG2-1:0]   ram_idx;
    logic                    commit;
    logic                    bad;
    logic [DATA_WIDTH-1:0]   rd_val;

    // Handshake: req/we/addr/wdata/be are sampled on a rising edge only while
    // busy=0; ready is a one-cycle pulse, and rdata/err are meaningful with it.
    assign busy = (state != S_IDLE);

    // With no wait states the commit edge is also the sampling edge, so the
    // access is taken straight from the ports instead of the latched copy.
    assign acc_we    = (state == S_IDLE) ? we    : we_q;
    assign acc_addr  = (state == S_IDLE) ? addr  : addr_q;
    assign acc_wdata = (state == S_IDLE) ? wdata : wdata_q;
    assign acc_be    = (state == S_IDLE) ? be    : be_q;

    assign offset  = acc_addr - IO_BASE;
    assign in_io   = (offset < ADDR_WIDTH'(16));
    assign io_sel  = offset[3:2];
    assign ram_idx = acc_addr[DEPTH_LOG2+1:2];
    assign commit  = (state_nxt == S_RESP);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (req) state_nxt = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
            S_WAIT: if (wcnt == WS_LAST) state_nxt = S_RESP;
            S_RESP: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        rd_val = '0;
        bad    = 1'b0;
        if (!in_io) begin
            rd_val = mem[ram_idx];
        end else begin
            case (io_sel)
                2'd0: rd_val = gpio_out;
                2'd1: begin rd_val = cyc_cnt; bad = acc_we; end
                2'd2: begin rd_val = {{(DATA_WIDTH-4){1'b0}}, WS4}; bad = acc_we; end
                default: bad = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            wcnt    <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_WAIT && state_nxt == S_WAIT) wcnt <= wcnt + 4'd1;
            else                                        wcnt <= '0;
            if (state == S_IDLE && req) begin
                we_q    <= we;
                addr_q  <= addr;
                wdata_q <= wdata;
                be_q    <= be;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cyc_cnt  <= '0;
            ready    <= 1'b0;
            err      <= 1'b0;
            rdata    <= '0;
            gpio_out <= '0;
        end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
            ready   <= commit;
            err     <= commit && bad;
            if (commit && !acc_we) rdata <= rd_val;
            if (commit && acc_we && in_io && io_sel == 2'd0) begin
                for (int i = 0; i < NB; i++)
                    if (acc_be[i]) gpio_out[8*i +: 8] <= acc_wdata[8*i +: 8];
            end
        end
    end

    // Storage has no reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (commit && acc_we && !in_io) begin
            for (int i = 0; i < NB; i++)
                if (acc_be[i]) mem[ram_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
        end
    end

endmodule

// File: tb/tb_dmem_mmio.sv
// Self-checking bench for dmem_mmio with WAIT_STATES=2: driver tasks, an
// expected-response queue popped on every ready, and a final report line.
module tb_dmem_mmio;

  localparam int WS = 2;
  localparam logic [31:0] IO_BASE = 32'hFFFF_0000;

  logic        clk;
  logic        reset;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        busy;
  logic        ready;
  logic [31:0] rdata;
  logic        err;
  logic [31:0] gpio_out;

  int n_checks = 0;
  int n_err = 0;

  // {is_read, err, rdata}
  logic [33:0] exp_q[$];
  logic [31:0] last_rd = 32'h0;
  logic [31:0] model [0:63];
  int unsigned edge_n;

  dmem_mmio #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .DEPTH_LOG2(6),
    .WAIT_STATES(WS),
    .IO_BASE(IO_BASE)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .we(we),
    .addr(addr),
    .wdata(wdata),
    .be(be),
    .busy(busy),
    .ready(ready),
    .rdata(rdata),
    .err(err),
    .gpio_out(gpio_out)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cycle counter reference: clocks since the last reset release
  always @(posedge clk or posedge reset) begin
    if (reset) edge_n <= 0;
    else       edge_n <= edge_n + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard
  always @(negedge clk) begin
    if (ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_ready", 1, 0);
      end else begin
        logic [33:0] e;
        e = exp_q.pop_front();
        check("err", err, e[32]);
        if (e[33]) begin
          check("rdata", rdata, e[31:0]);
          last_rd = e[31:0];
        end else begin
          check("rdata_held", rdata, last_rd);
        end
      end
    end
  end

  task automatic do_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] b, input logic [31:0] exp_d, input logic exp_e,
                           input logic is_cnt, input logic hold, output logic [31:0] obs);
    int n;
    int bz;
    int guard;
    logic [31:0] ed;
    guard = 0;
    @(negedge clk);
    while (busy && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    req = 1'b1; we = w; addr = a; wdata = d; be = b;
    @(posedge clk); #1;
    ed = is_cnt ? (edge_n + WS - 1) : exp_d;
    exp_q.push_back({~w, exp_e, ed});
    if (hold) begin
      we = 1'b1; addr = 32'h30; wdata = 32'h99; be = 4'hF;
    end else begin
      req = 1'b0; we = 1'($urandom_range(0, 1)); addr = $urandom; wdata = $urandom;
      be = 4'($urandom_range(0, 15));
    end
    n = 0;
    bz = busy ? 1 : 0;
    while (ready !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (busy) bz++;
    end
    check("ready_seen", ready, 1);
    check("latency", n, WS);
    check("busy_cycles", bz, WS + 1);
    obs = rdata;
    if (hold) begin
      @(negedge clk);
      req = 1'b0;
      @(posedge clk); #1;
      check("ghost_ignored", busy, 0);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b, input logic e);
    logic [31:0] o;
    do_access(1'b1, a, d, b, 32'h0, e, 1'b0, 1'b0, o);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp_d, input logic e);
    logic [31:0] o;
    do_access(1'b0, a, 32'h0, 4'h0, exp_d, e, 1'b0, 1'b0, o);
  endtask

  initial begin
    logic [31:0] v1, v2, o, d;
    int unsigned s1, s2;
    int idx;
    logic [3:0] b;

    req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_ready", ready, 0);
    check("rst_rdata", rdata, 0);
    check("rst_gpio", gpio_out, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("idle_busy", busy, 0);
      check("idle_ready", ready, 0);
      check("idle_rdata", rdata, 0);
      check("idle_gpio", gpio_out, 0);
    end

    // basic write/read, byte enables, aliasing
    wr(32'h10, 32'hDEAD_BEEF, 4'hF, 1'b0);
    rd(32'h10, 32'hDEAD_BEEF, 1'b0);
    wr(32'h10, 32'h1122_3344, 4'b0101, 1'b0);
    rd(32'h10, 32'hDE22_BE44, 1'b0);
    rd(32'h110, 32'hDE22_BE44, 1'b0);
    wr(32'h20, 32'hCAFE_F00D, 4'hF, 1'b0);
    wr(32'h30, 32'h0, 4'hF, 1'b0);
    wr(32'h40, 32'h0, 4'h0, 1'b0);

    // GPIO
    wr(IO_BASE, 32'hA5A5_A5A5, 4'b0011, 1'b0);
    check("gpio_out", gpio_out, 32'h0000_A5A5);
    rd(IO_BASE + 32'd1, 32'h0000_A5A5, 1'b0);

    // cycle counter spacing
    s1 = edge_n;
    do_access(1'b0, IO_BASE + 32'd4, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1, 1'b0, v1);
    repeat ($urandom_range(3, 12)) @(posedge clk);
    s2 = edge_n;
    do_access(1'b0, IO_BASE + 32'd4, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1, 1'b0, v2);
    s1 = s2 - s1;
    s2 = v2 - v1;
    check("cnt_positive", (s2 > 0), 1);

    // invalid I/O, status
    wr(IO_BASE + 32'd4, 32'h0, 4'hF, 1'b1);
    do_access(1'b0, IO_BASE + 32'd4, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1, 1'b0, o);
    rd(IO_BASE + 32'd8, 32'h2, 1'b0);
    wr(IO_BASE + 32'd8, 32'hFFFF_FFFF, 4'hF, 1'b1);
    rd(IO_BASE + 32'd12, 32'h0, 1'b1);
    wr(IO_BASE + 32'd12, 32'hFFFF_FFFF, 4'hF, 1'b1);
    check("gpio_kept", gpio_out, 32'h0000_A5A5);

    // random RAM traffic on words 40..47 through aliased addresses
    for (int i = 0; i < 8; i++) begin
      d = $urandom;
      model[40 + i] = d;
      wr(32'((40 + i) << 2), d, 4'hF, 1'b0);
    end
    for (int i = 0; i < 10; i++) begin
      idx = $urandom_range(40, 47);
      d = $urandom;
      b = 4'($urandom_range(0, 15));
      for (int k = 0; k < 4; k++)
        if (b[k]) model[idx][8*k +: 8] = d[8*k +: 8];
      wr(32'($urandom_range(0, 15) << 8) | 32'(idx << 2) | 32'($urandom_range(0, 3)), d, b, 1'b0);
      rd(32'($urandom_range(0, 15) << 8) | 32'(idx << 2), model[idx], 1'b0);
    end

    // request held high while busy must not be queued
    do_access(1'b1, 32'h40, 32'h5555_AAAA, 4'hF, 32'h0, 1'b0, 1'b0, 1'b1, o);
    rd(32'h30, 32'h0, 1'b0);
    rd(32'h40, 32'h5555_AAAA, 1'b0);

    // reset during WAIT aborts the access
    @(negedge clk);
    while (busy) @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h1234_5678; be = 4'hF;
    @(posedge clk); #1;
    req = 1'b0;
    check("abort_busy_before", busy, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    last_rd = 32'h0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_ready", ready, 0);
    check("abort_rdata", rdata, 0);
    check("abort_gpio", gpio_out, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("abort_no_ready", ready, 0);
    end
    rd(32'h20, 32'hCAFE_F00D, 1'b0);
    do_access(1'b0, IO_BASE + 32'd4, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1, 1'b0, o);

    repeat (4) @(posedge clk);
    check("queue_empty", exp_q.size(), 0);
    check("cnt_diff", s2, s1);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
